im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//  Writer side of the instruction memory: fills the fetch unit's 1K-word IM from a byte
//  stream (valid/ready), in place of a $readmemh preload. Holds the CPU in reset until a
//  complete, checksum-verified image is written. Sits between a host link and the IM write port.
// PARAMETERS
//  DEPTH    1024          IM depth in words; legal word count is 1..DEPTH
//  ADDR_W   10            IM word-address width; clog2(DEPTH)
//  BASE_PC  32'h00003000  byte address of IM word 0; matches the fetch reset PC
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       in_data holds a valid byte
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts a byte this cycle
//  im_we      out  1       one-cycle IM write strobe
//  im_addr    out  ADDR_W  IM word index for the write
//  im_pc      out  32      BASE_PC + 4*im_addr, for trace/debug
//  im_wdata   out  32      instruction word to write
//  cpu_hold   out  1       hold the CPU in reset; equals ~done
//  done       out  1       image loaded and checksum OK; sticky
//  error      out  1       bad length or checksum; sticky
//  words_wr   out  ADDR_W+1  words written so far
// BEHAVIOUR
//  - Byte accepted on a posedge where in_valid && in_ready. in_data may change only after
//    acceptance. in_ready is driven from state only, never from in_valid.
//  - Stream format, all fields big-endian:
//      LEN_HI, LEN_LO            16-bit word count N
//      N*4 data bytes            MSB first per word
//      CSUM                      XOR of all data bytes; length bytes excluded
//  - Reset values: state=S_LEN_HI, in_ready=1, im_we=0, im_addr=0, im_wdata=0, done=0,
//    error=0, words_wr=0, cpu_hold=1, internal xor=0, byte counter=0.
//  - FSM:
//      S_LEN_HI  accept byte -> len[15:8]; go to S_LEN_LO
//      S_LEN_LO  accept byte -> len[7:0]
//                if len==0 or len>DEPTH -> S_ERR, else -> S_DATA
//      S_DATA    shift each byte into a 32-bit assembly reg ({reg[23:0],byte}); xor ^= byte
//                on the 4th byte of a word: register im_wdata=assembled word and
//                im_addr=words_wr, pulse im_we=1 for exactly the next cycle, words_wr++
//                after the 4th byte of word N-1 -> S_CSUM
//      S_CSUM    accept byte; byte==xor -> S_DONE, else -> S_ERR
//      S_DONE    in_ready=0, done=1; terminal until reset
//      S_ERR     in_ready=0, error=1; terminal until reset
//  - Write latency: im_we rises 1 cycle after the 4th byte of a word is accepted.
//    in_ready stays high during that cycle; back-to-back bytes at full rate are legal.
//  - The last word's im_we pulse may coincide with the first S_CSUM cycle; both proceed.
//  - done/error assert the cycle after the CSUM byte is accepted.
//    done and error are mutually exclusive.
//  - In S_ERR, words already written stay in the IM; no rollback.
//    cpu_hold stays 1 because done=0.
//  - im_addr and im_wdata hold their last values when im_we=0.
//    im_pc = BASE_PC + {im_addr,2'b00}, zero-extended to 32 bits.
//  - Reset mid-load: all state returns to reset values on the next edge and any partial
//    word is discarded. The next byte is treated as LEN_HI.
//  - in_valid gaps of any length are allowed in every accepting state; no timeout.
// TESTING
//  1 Stream 00 01 | 24 08 00 05 | 29, full rate -> one im_we, addr 0, wdata 32'h24080005,
//    im_pc 32'h3000; done=1 and cpu_hold=0 one cycle after the 29 byte.
//  2 N=3, words 11111111/22222222/0000000C, correct CSUM 0x0C, random in_valid gaps ->
//    im_we at addr 0,1,2 with matching data; words_wr=3; done=1.
//  3 Stream 00 00 -> error=1 after LEN_LO, in_ready=0, no im_we.
//    Stream 04 01 (N=1025) -> error=1, no im_we.
//  4 N=1 with a wrong CSUM byte -> word is still written; error=1, done=0, cpu_hold=1.
//  5 N=DEPTH=1024 -> last write at addr 10'h3FF, im_pc 32'h3FFC; words_wr=1024; done=1.
//  6 reset asserted after 2 data bytes of N=2 -> no im_we. A following full N=1 stream
//    writes addr 0 and reaches done.

Source files
------------

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//   Writer side of the fetch unit's instruction memory. Parses a big-endian
//   byte stream (valid/ready) of the form
//     LEN_HI, LEN_LO, N*4 data bytes (MSB first per word), CSUM
//   writes each assembled word to the IM write port, and keeps the CPU held in
//   reset until a complete image whose XOR checksum matches has been written.
//
// Parameters
//   DEPTH    IM depth in words; legal word count is 1..DEPTH
//   ADDR_W   IM word-address width, clog2(DEPTH)
//   BASE_PC  byte address of IM word 0 (the fetch reset PC)
//
// Ports
//   clk       in   1         clock, rising edge
//   reset     in   1         synchronous, active-high
//   in_valid  in   1         in_data holds a valid byte
//   in_data   in   8         stream byte
//   in_ready  out  1         loader accepts a byte this cycle
//   im_we     out  1         one-cycle IM write strobe
//   im_addr   out  ADDR_W    IM word index for the write
//   im_pc     out  32        BASE_PC + 4*im_addr, for trace/debug
//   im_wdata  out  32        instruction word to write
//   cpu_hold  out  1         hold the CPU in reset (~done)
//   done      out  1         image loaded and checksum OK; sticky
//   error     out  1         bad length or checksum; sticky
//   words_wr  out  ADDR_W+1  words written so far
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int          DEPTH   = 1024,
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_pc,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_wr
);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [31:0]       r_asm;
  logic [7:0]        r_xor;
  logic [1:0]        r_byte_cnt;
  logic              r_im_we;
  logic [ADDR_W-1:0] r_im_addr;
  logic [31:0]       r_im_wdata;
  logic [ADDR_W:0]   r_words_wr;

  logic              w_accept;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic              w_last_word;
  logic              w_state_legal;

  // NOTE: in_ready depends on state only; feeding in_valid into it would
  // create a combinational loop with any upstream that waits on in_ready.
  assign in_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                    (r_state == S_DATA)   || (r_state == S_CSUM);

  assign w_accept = in_valid && in_ready;

  // Full word count as it will be once the LEN_LO byte lands.
  assign w_len     = {r_len[15:8], in_data};
  assign w_len_bad = (w_len == 16'd0) || (w_len > 16'(DEPTH));

  // The word being completed now is the final one when words_wr + 1 == N.
  assign w_last_word = ({{(15 - ADDR_W){1'b0}}, r_words_wr} + 16'd1) == r_len;

  assign w_state_legal = (r_state <= S_ERR);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LEN_HI;
      r_len      <= 16'd0;
      r_asm      <= 32'd0;
      r_xor      <= 8'd0;
      r_byte_cnt <= 2'd0;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= 32'd0;
      r_words_wr <= '0;
    end else begin
      // Write strobe is a single-cycle pulse; im_addr/im_wdata hold.
      r_im_we <= 1'b0;

      if (!w_state_legal) begin
        r_state <= S_ERR;
      end else if (w_accept) begin
        case (r_state)
          S_LEN_HI: begin
            r_len[15:8] <= in_data;
            r_state     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            r_len[7:0] <= in_data;
            r_state    <= w_len_bad ? S_ERR : S_DATA;
          end
          S_DATA: begin
            r_asm      <= {r_asm[23:0], in_data};
            r_xor      <= r_xor ^ in_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_im_wdata <= {r_asm[23:0], in_data};
              r_im_addr  <= r_words_wr[ADDR_W-1:0];
              r_im_we    <= 1'b1;
              r_words_wr <= r_words_wr + 1'b1;
              if (w_last_word) begin
                r_state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            r_state <= (in_data == r_xor) ? S_DONE : S_ERR;
          end
          default: begin
            // S_DONE / S_ERR never accept; nothing to do.
          end
        endcase
      end
    end
  end

  assign im_we    = r_im_we;
  assign im_addr  = r_im_addr;
  assign im_wdata = r_im_wdata;
  assign im_pc    = BASE_PC + {{(30 - ADDR_W){1'b0}}, r_im_addr, 2'b00};
  assign words_wr = r_words_wr;
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_ERR);
  assign cpu_hold = ~done;

endmodule

// File: tb/tb_im_loader.sv
// -----------------------------------------------------------------------------
// tb_im_loader
//   Randomised bench for im_loader. A stream-level reference model derives the
//   expected IM writes and final status from the byte stream; expected writes
//   go into a scoreboard queue that an independent monitor drains on im_we.
// -----------------------------------------------------------------------------
module tb_im_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_pc;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [10:0] words_wr;

  im_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (10),
    .BASE_PC(32'h0000_3000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .im_we   (im_we),
    .im_addr (im_addr),
    .im_pc   (im_pc),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error),
    .words_wr(words_wr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] stim[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         stalled;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every im_we must match the oldest outstanding expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && im_we === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_im_we", 32'(im_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("im_addr", 32'(im_addr), 32'(e.addr));
          check("im_wdata", im_wdata, e.data);
          check("im_pc", im_pc, 32'h3000 + 32'(e.addr) * 4);
        end
      end
    end
  end

  // Reference model: interprets the stream by its format rules.
  task automatic model(output bit e_done, output bit e_err, output int e_words);
    int         n;
    logic [7:0] x;
    logic [31:0] w;
    n = int'({stim[0], stim[1]});
    e_done = 0; e_err = 0; e_words = 0;
    if (n == 0 || n > DEPTH) begin
      e_err = 1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
      for (int k = 0; k < 4; k++) x ^= stim[2+4*i+k];
      sb.push_back('{addr: 10'(i), data: w});
    end
    e_words = n;
    if (stim[2+4*n] == x) e_done = 1;
    else e_err = 1;
  endtask

  // Entered and left at a negedge; bounded wait on in_ready.
  task automatic send_byte(input logic [7:0] b);
    int waits = 0;
    if (stalled) return;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      stalled = 1;
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic send_stim(input int gap_max);
    stalled = 0;
    foreach (stim[i]) begin
      if (gap_max > 0 && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, gap_max)) @(negedge clk);
      send_byte(stim[i]);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic build(input int n, input bit good, input bit zero_data);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] n16;
    stim.delete();
    n16 = 16'(n);
    stim.push_back(n16[15:8]);
    stim.push_back(n16[7:0]);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = zero_data ? 32'd0 : $urandom;
      for (int k = 3; k >= 0; k--) begin
        stim.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
    stim.push_back(good ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
  endtask

  // Run the stream in stim through model and DUT, then check final status.
  task automatic run(input string name, input int gap_max);
    bit e_done, e_err;
    int e_words;
    model(e_done, e_err, e_words);
    send_stim(gap_max);
    check({name, "_done"}, 32'(done), 32'(e_done));
    check({name, "_error"}, 32'(error), 32'(e_err));
    check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!e_done));
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_words_wr"}, 32'(words_wr), 32'(e_words));
    repeat (2) @(negedge clk);
    #1;
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
    check({name, "_sticky"}, 32'({done, error}), 32'({e_done, e_err}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_im_pc", im_pc, 32'h3000);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_words_wr", 32'(words_wr), 32'd0);

    // Single word, full rate.
    stim = '{8'h00, 8'h01, 8'h24, 8'h08, 8'h00, 8'h05, 8'h29};
    run("t1", 0);

    // Three words with random gaps; checksum 0x0C.
    do_reset();
    stim = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22,
             8'h22, 8'h22, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h0C};
    run("t2", 4);

    // Illegal lengths: 0 and DEPTH+1.
    do_reset();
    stim = '{8'h00, 8'h00};
    run("t3_zero", 0);
    do_reset();
    stim = '{8'h04, 8'h01};
    run("t3_over", 2);

    // Wrong checksum still writes the word.
    do_reset();
    build(1, 1'b0, 1'b0);
    run("t4", 0);

    // Full-depth image.
    do_reset();
    build(DEPTH, 1'b1, 1'b0);
    run("t5", 0);

    // Reset mid-word, then a clean single-word load.
    do_reset();
    stim = '{8'h00, 8'h02, 8'hAB, 8'hCD};
    send_stim(0);
    do_reset();
    check("t6_words_wr", 32'(words_wr), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    build(1, 1'b1, 1'b0);
    run("t6", 2);

    // Random images: lengths, data, checksum validity and gaps.
    for (int t = 0; t < 10; t++) begin
      do_reset();
      build($urandom_range(1, 20), ($urandom_range(0, 3) != 0), 1'b0);
      run($sformatf("rnd%0d", t), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
